// File: rtl/uart_rx_ctrl.sv
// UART receive control wrapper: idle-gated frame configuration, show-ahead
// receive FIFO with host valid/ready, sticky overflow and saturating error count.
module uart_rx_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  cfg_wr,
   input  logic                  cfg_par_en,
   input  logic                  cfg_par_typ,
   input  logic [5:0]            cfg_prescale,
   output logic                  cfg_rej,
   output logic                  cfg_pend,
   output logic                  Par_En,
   output logic                  Par_Typ,
   output logic [5:0]            Prescale,
   input  logic                  rx_busy,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_valid,
   input  logic                  rx_par_err,
   input  logic                  rx_stp_err,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [ADDR_W:0]       fifo_count,
   output logic                  ovf,
   output logic [7:0]            err_cnt,
   input  logic                  clr
);

   typedef enum logic {C_IDLE, C_PEND} cstate_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

   cstate_t                state_q, state_d;
   logic                   sh_pe_q, sh_pe_d, sh_pt_q, sh_pt_d;
   logic [5:0]             sh_ps_q, sh_ps_d;
   logic                   par_en_q, par_en_d, par_typ_q, par_typ_d;
   logic [5:0]             prescale_q, prescale_d;
   logic                   rej_q, rej_d;
   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
   logic [ADDR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic                   ovf_q, ovf_d;
   logic [7:0]             err_q, err_d;

   logic                   cfg_legal, empty, full, push, pop;
   logic [ADDR_W:0]        count;

   assign cfg_legal = (cfg_prescale == 6'd8) || (cfg_prescale == 6'd16) || (cfg_prescale == 6'd32);
   assign count     = wr_ptr_q - rd_ptr_q;
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_C);
   assign pop       = !empty && rd_ready;
   // A full FIFO still accepts a byte when the host frees a slot this cycle
   assign push      = rx_valid && (!full || pop);

   always_comb begin
      state_d    = state_q;
      sh_pe_d    = sh_pe_q;
      sh_pt_d    = sh_pt_q;
      sh_ps_d    = sh_ps_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      prescale_d = prescale_q;
      rej_d      = 1'b0;
      if (state_q == C_PEND && !rx_busy) begin
         par_en_d   = sh_pe_q;
         par_typ_d  = sh_pt_q;
         prescale_d = sh_ps_q;
         state_d    = C_IDLE;
      end
      // A write coinciding with an apply is captured after the old shadow moves out
      if (cfg_wr) begin
         if (cfg_legal) begin
            sh_pe_d = cfg_par_en;
            sh_pt_d = cfg_par_typ;
            sh_ps_d = cfg_prescale;
            state_d = C_PEND;
         end else begin
            rej_d = 1'b1;
         end
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[ADDR_W-1:0]] = rx_data;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_comb begin
      ovf_d = ovf_q;
      err_d = err_q;
      if (clr) begin
         ovf_d = 1'b0;
         err_d = '0;
      end
      if (rx_valid && !push) ovf_d = 1'b1;
      if (rx_par_err || rx_stp_err)
         err_d = clr ? 8'd1 : ((err_q == 8'hFF) ? err_q : err_q + 8'd1);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q    <= C_IDLE;
         sh_pe_q    <= 1'b0;
         sh_pt_q    <= 1'b0;
         sh_ps_q    <= 6'd8;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         prescale_q <= 6'd8;
         rej_q      <= 1'b0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ovf_q      <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         sh_pe_q    <= sh_pe_d;
         sh_pt_q    <= sh_pt_d;
         sh_ps_q    <= sh_ps_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         prescale_q <= prescale_d;
         rej_q      <= rej_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ovf_q      <= ovf_d;
         err_q      <= err_d;
      end
   end

   assign cfg_rej    = rej_q;
   assign cfg_pend   = (state_q == C_PEND);
   assign Par_En     = par_en_q;
   assign Par_Typ    = par_typ_q;
   assign Prescale   = prescale_q;
   assign rd_valid   = !empty;
   assign rd_data    = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
   assign fifo_count = count;
   assign ovf        = ovf_q;
   assign err_cnt    = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: config vector table, hand-written FIFO/error
// sequences, then randomized traffic against a queue-based reference model.
module tb_uart_rx_ctrl;
   localparam int DW = 8, DEPTH = 4, AW = 2;

   logic          Clk = 1'b0, Rst = 1'b0;
   logic          cfg_wr, cfg_par_en, cfg_par_typ;
   logic [5:0]    cfg_prescale;
   logic          cfg_rej, cfg_pend, Par_En, Par_Typ;
   logic [5:0]    Prescale;
   logic          rx_busy, rx_valid, rx_par_err, rx_stp_err;
   logic [DW-1:0] rx_data, rd_data;
   logic          rd_valid, rd_ready, ovf, clr;
   logic [AW:0]   fifo_count;
   logic [7:0]    err_cnt;

   uart_rx_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .Clk(Clk), .Rst(Rst), .cfg_wr(cfg_wr), .cfg_par_en(cfg_par_en),
      .cfg_par_typ(cfg_par_typ), .cfg_prescale(cfg_prescale), .cfg_rej(cfg_rej),
      .cfg_pend(cfg_pend), .Par_En(Par_En), .Par_Typ(Par_Typ), .Prescale(Prescale),
      .rx_busy(rx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
      .ovf(ovf), .err_cnt(err_cnt), .clr(clr));

   always #5 Clk = ~Clk;

   int tests = 0, fails = 0;

   typedef struct {
      logic       wr, pe, pt, busy;
      logic [5:0] ps;
      logic       e_pend, e_rej, e_pe, e_pt;
      logic [5:0] e_ps;
   } cfg_vec_t;
   cfg_vec_t tv[$];

   function automatic cfg_vec_t mk(logic wr, logic pe, logic pt, logic [5:0] ps, logic busy,
                                   logic e_pend, logic e_rej, logic e_pe, logic e_pt, logic [5:0] e_ps);
      cfg_vec_t v;
      v.wr = wr; v.pe = pe; v.pt = pt; v.ps = ps; v.busy = busy;
      v.e_pend = e_pend; v.e_rej = e_rej; v.e_pe = e_pe; v.e_pt = e_pt; v.e_ps = e_ps;
      return v;
   endfunction

   function automatic logic legal(logic [5:0] ps);
      return ps == 6'd8 || ps == 6'd16 || ps == 6'd32;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_in();
      cfg_wr = 0; cfg_par_en = 0; cfg_par_typ = 0; cfg_prescale = 6'd8;
      rx_busy = 0; rx_data = '0; rx_valid = 0; rx_par_err = 0; rx_stp_err = 0;
      rd_ready = 0; clr = 0;
   endtask

   task automatic do_reset();
      idle_in();
      Rst = 0;
      step(); step();
      Rst = 1;
      step();
   endtask

   task automatic push_byte(input logic [DW-1:0] d);
      rx_valid = 1; rx_data = d;
      step();
      rx_valid = 0;
   endtask

   // reference model state
   logic [DW-1:0] m_q[$];
   logic          m_pend, m_shpe, m_shpt, m_pe, m_pt, m_rej, m_ovf, m_pop;
   logic [5:0]    m_shps, m_ps;
   int            m_err;

   initial begin
      do_reset();
      chk("rst.par_en", 32'(Par_En), 0);
      chk("rst.par_typ", 32'(Par_Typ), 0);
      chk("rst.prescale", 32'(Prescale), 8);
      chk("rst.cfg_pend", 32'(cfg_pend), 0);
      chk("rst.cfg_rej", 32'(cfg_rej), 0);
      chk("rst.rd_valid", 32'(rd_valid), 0);
      chk("rst.fifo_count", 32'(fifo_count), 0);
      chk("rst.rd_data", 32'(rd_data), 0);
      chk("rst.ovf", 32'(ovf), 0);
      chk("rst.err_cnt", 32'(err_cnt), 0);

      //          wr pe pt ps  busy | pend rej pe pt ps
      tv.push_back(mk(1, 1, 1, 12, 0,   0, 1, 0, 0, 8));
      tv.push_back(mk(0, 0, 0,  8, 0,   0, 0, 0, 0, 8));
      tv.push_back(mk(1, 1, 1, 16, 1,   1, 0, 0, 0, 8));
      for (int i = 0; i < 9; i++) tv.push_back(mk(0, 0, 0, 8, 1, 1, 0, 0, 0, 8));
      tv.push_back(mk(0, 0, 0,  8, 0,   0, 0, 1, 1, 16));
      tv.push_back(mk(1, 0, 0, 12, 0,   0, 1, 1, 1, 16));
      tv.push_back(mk(0, 0, 0,  8, 0,   0, 0, 1, 1, 16));
      tv.push_back(mk(1, 0, 0, 32, 0,   1, 0, 1, 1, 16));
      tv.push_back(mk(0, 0, 0,  8, 0,   0, 0, 0, 0, 32));
      tv.push_back(mk(1, 1, 0,  8, 1,   1, 0, 0, 0, 32));
      tv.push_back(mk(1, 1, 1, 16, 1,   1, 0, 0, 0, 32));
      tv.push_back(mk(1, 0, 1,  8, 0,   1, 0, 1, 1, 16));
      tv.push_back(mk(0, 0, 0,  8, 0,   0, 0, 0, 1, 8));
      tv.push_back(mk(1, 1, 1, 32, 1,   1, 0, 0, 1, 8));
      tv.push_back(mk(1, 0, 0, 12, 1,   1, 1, 0, 1, 8));
      tv.push_back(mk(0, 0, 0,  8, 0,   0, 0, 1, 1, 32));
      foreach (tv[i]) begin
         cfg_wr = tv[i].wr; cfg_par_en = tv[i].pe; cfg_par_typ = tv[i].pt;
         cfg_prescale = tv[i].ps; rx_busy = tv[i].busy;
         step();
         chk($sformatf("cfg%0d.pend", i), 32'(cfg_pend), 32'(tv[i].e_pend));
         chk($sformatf("cfg%0d.rej", i), 32'(cfg_rej), 32'(tv[i].e_rej));
         chk($sformatf("cfg%0d.par_en", i), 32'(Par_En), 32'(tv[i].e_pe));
         chk($sformatf("cfg%0d.par_typ", i), 32'(Par_Typ), 32'(tv[i].e_pt));
         chk($sformatf("cfg%0d.prescale", i), 32'(Prescale), 32'(tv[i].e_ps));
      end
      idle_in();

      // overflow: five bytes into a four-entry FIFO
      do_reset();
      rx_valid = 1; rx_data = 8'hA1;
      chk("fifo.valid_before_push", 32'(rd_valid), 0);
      step();
      chk("fifo.valid_after_push", 32'(rd_valid), 1);
      chk("fifo.head_a1", 32'(rd_data), 32'h A1);
      for (int k = 1; k < 5; k++) push_byte(8'(8'hA1 + k));
      chk("ovf.count", 32'(fifo_count), 4);
      chk("ovf.flag", 32'(ovf), 1);
      rd_ready = 1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf.pop%0d", k), 32'(rd_data), 32'(8'hA1 + k));
         step();
      end
      chk("ovf.empty_valid", 32'(rd_valid), 0);
      chk("ovf.empty_count", 32'(fifo_count), 0);
      chk("ovf.empty_data", 32'(rd_data), 0);
      step();
      chk("fifo.ready_on_empty", 32'(fifo_count), 0);
      rd_ready = 0; clr = 1;
      step();
      clr = 0;
      chk("ovf.clr", 32'(ovf), 0);

      // full with simultaneous push and pop
      for (int k = 0; k < 4; k++) push_byte(8'(8'hC0 + k));
      rx_valid = 1; rx_data = 8'hB0; rd_ready = 1;
      step();
      rx_valid = 0;
      chk("pp.count", 32'(fifo_count), 4);
      chk("pp.ovf", 32'(ovf), 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("pp.pop%0d", k), 32'(rd_data), (k == 3) ? 32'hB0 : 32'(8'hC1 + k));
         step();
      end
      rd_ready = 0;
      chk("pp.drained", 32'(rd_valid), 0);

      // overflow in the same cycle as clr: overflow wins
      for (int k = 0; k < 4; k++) push_byte(8'(k));
      rx_valid = 1; clr = 1;
      step();
      rx_valid = 0;
      chk("ovf_clr.same", 32'(ovf), 1);
      step();
      clr = 0;
      chk("ovf_clr.after", 32'(ovf), 0);
      chk("ovf_clr.fifo_kept", 32'(fifo_count), 4);

      // error counter saturation
      do_reset();
      rx_stp_err = 1;
      for (int i = 0; i < 300; i++) begin
         rx_par_err = (i == 50);
         step();
         if (i == 99) chk("err.at100", 32'(err_cnt), 100);
      end
      rx_stp_err = 0;
      chk("err.sat", 32'(err_cnt), 255);
      rx_par_err = 1; clr = 1;
      step();
      chk("err.clr_with_err", 32'(err_cnt), 1);
      rx_par_err = 0;
      step();
      clr = 0;
      chk("err.clr", 32'(err_cnt), 0);

      // randomized traffic against the reference model
      do_reset();
      m_q.delete();
      m_pend = 0; m_shpe = 0; m_shpt = 0; m_shps = 8;
      m_pe = 0; m_pt = 0; m_ps = 8; m_rej = 0; m_ovf = 0; m_err = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if ($urandom % 4 == 0) rx_busy = ~rx_busy;
         cfg_wr = ($urandom % 6 == 0);
         cfg_par_en = 1'($urandom); cfg_par_typ = 1'($urandom);
         case ($urandom % 5)
            0: cfg_prescale = 6'd8;
            1: cfg_prescale = 6'd16;
            2: cfg_prescale = 6'd32;
            default: cfg_prescale = 6'($urandom);
         endcase
         rx_valid = ($urandom % 2 == 0); rx_data = 8'($urandom);
         rd_ready = ($urandom % 100) < ((cyc < 300) ? 30 : 70);
         rx_par_err = ($urandom % 8 == 0); rx_stp_err = ($urandom % 8 == 0);
         clr = ($urandom % 20 == 0);

         m_rej = cfg_wr && !legal(cfg_prescale);
         if (m_pend && !rx_busy) begin
            m_pe = m_shpe; m_pt = m_shpt; m_ps = m_shps; m_pend = 0;
         end
         if (cfg_wr && legal(cfg_prescale)) begin
            m_shpe = cfg_par_en; m_shpt = cfg_par_typ; m_shps = cfg_prescale; m_pend = 1;
         end
         if (clr) begin m_ovf = 0; m_err = 0; end
         if (rx_par_err || rx_stp_err) m_err = clr ? 1 : ((m_err < 255) ? m_err + 1 : 255);
         m_pop = (m_q.size() > 0) && rd_ready;
         if (rx_valid && m_q.size() == DEPTH && !m_pop) m_ovf = 1;
         else if (rx_valid) m_q.push_back(rx_data);
         if (m_pop) void'(m_q.pop_front());

         step();
         chk("rnd.par_en", 32'(Par_En), 32'(m_pe));
         chk("rnd.par_typ", 32'(Par_Typ), 32'(m_pt));
         chk("rnd.prescale", 32'(Prescale), 32'(m_ps));
         chk("rnd.cfg_pend", 32'(cfg_pend), 32'(m_pend));
         chk("rnd.cfg_rej", 32'(cfg_rej), 32'(m_rej));
         chk("rnd.fifo_count", 32'(fifo_count), 32'(m_q.size()));
         chk("rnd.rd_valid", 32'(rd_valid), 32'(m_q.size() > 0));
         chk("rnd.rd_data", 32'(rd_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
         chk("rnd.ovf", 32'(ovf), 32'(m_ovf));
         chk("rnd.err_cnt", 32'(err_cnt), 32'(m_err));
      end

      // asynchronous reset mid-frame with data held and a config pending
      idle_in();
      rx_busy = 1;
      push_byte(8'h5A);
      cfg_wr = 1; cfg_par_en = 1; cfg_prescale = 6'd16; rx_valid = 1; rx_stp_err = 1;
      step();
      idle_in(); rx_busy = 1;
      #2 Rst = 0;
      #1;
      chk("arst.rd_valid", 32'(rd_valid), 0);
      chk("arst.fifo_count", 32'(fifo_count), 0);
      chk("arst.cfg_pend", 32'(cfg_pend), 0);
      chk("arst.prescale", 32'(Prescale), 8);
      chk("arst.err_cnt", 32'(err_cnt), 0);
      Rst = 1;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control and buffering wrapper around the UART receive core (FSM + sampler + deserializer + checkers).
- Holds the frame configuration (parity enable, parity type, oversampling prescale) and drives it to the RX core. A new configuration is applied only while the RX core is idle, so it never changes mid-frame.
- Captures each validated byte into a small show-ahead FIFO read by the host through a valid/ready handshake.
- Accumulates frame-error statistics and a sticky overflow flag.

Parameters:
DATA_WIDTH, 8, received data width.
FIFO_DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
ADDR_W, 2, log2(FIFO_DEPTH).

Ports:
Clk  in  1  system clock.
Rst  in  1  asynchronous, active-low reset.
cfg_wr  in  1  host config write strobe, one cycle.
cfg_par_en  in  1  requested parity enable.
cfg_par_typ  in  1  requested parity type; 0 = even, 1 = odd.
cfg_prescale  in  6  requested oversampling ratio; legal values are 8, 16 and 32.
cfg_rej  out  1  one-cycle pulse: cfg_wr was rejected.
cfg_pend  out  1  a configuration is waiting to be applied.
Par_En  out  1  applied parity enable, to the RX core.
Par_Typ  out  1  applied parity type, to the RX core.
Prescale  out  6  applied prescale, to the RX core.
rx_busy  in  1  RX core is not in IDLE.
rx_data  in  DATA_WIDTH  deserializer parallel output.
rx_valid  in  1  Data_Valid pulse from the RX core.
rx_par_err  in  1  parity error pulse.
rx_stp_err  in  1  stop error pulse.
rd_data  out  DATA_WIDTH  FIFO head data.
rd_valid  out  1  FIFO not empty.
rd_ready  in  1  host accepts rd_data.
fifo_count  out  ADDR_W+1  number of entries held.
ovf  out  1  sticky overflow flag.
err_cnt  out  8  saturating frame-error count.
clr  in  1  clears ovf and err_cnt.

Behaviour:
- Reset (Rst low, asynchronous):
  - Par_En=0, Par_Typ=0, Prescale=8.
  - cfg_pend=0, cfg_rej=0.
  - FIFO empty: rd_valid=0, fifo_count=0, rd_data=0.
  - ovf=0, err_cnt=0.
  - Any pending configuration or FIFO contents are discarded; reset asserted mid-frame or mid-read has the same effect.
- Config FSM, states C_IDLE and C_PEND:
  - Legal cfg_wr in any state: the three fields are registered into a shadow and the FSM goes to C_PEND.
  - Illegal prescale: the whole write is ignored, cfg_rej pulses on the next cycle, and state and shadow are unchanged.
  - In C_PEND with rx_busy=0: the shadow is copied to Par_En/Par_Typ/Prescale at the next edge and the FSM returns to C_IDLE.
  - Minimum latency from cfg_wr to output update is 2 cycles.
  - In C_PEND with rx_busy=1: hold, with outputs unchanged.
  - Back-to-back cfg_wr while pending: last write wins.
  - cfg_wr in the same cycle as an apply: the old shadow is applied, the new value is captured, and the FSM stays in C_PEND.
  - cfg_pend=1 exactly when the state is C_PEND.
- FIFO (circular, read/write pointers ADDR_W+1 bits, wrapping at FIFO_DEPTH):
  - Push on rx_valid when not full, or when full and a pop occurs in the same cycle.
  - Pop on rd_valid && rd_ready.
  - Show-ahead: rd_data always shows the head. rd_valid rises 1 cycle after a push into an empty FIFO.
  - rx_valid while full with no pop: the byte is dropped, ovf is set, and count stays at FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged, no ovf.
  - rd_ready while empty: no effect.
- Error counter:
  - rx_par_err or rx_stp_err asserted increments err_cnt by 1; both in the same cycle count once.
  - Saturates at 255.
- clr:
  - Clears ovf and err_cnt next cycle; does not flush the FIFO or touch the configuration.
  - An error or overflow event in the same cycle as clr wins: err_cnt=1 or ovf=1 after that edge.

Test Plan:
- Reset, then idle -> Par_En=0, Par_Typ=0, Prescale=8, rd_valid=0, fifo_count=0, err_cnt=0.
- cfg_wr {par_en=1, typ=1, prescale=16} with rx_busy=1 held 10 cycles, then 0 -> cfg_pend=1 throughout the busy period; Prescale=16, Par_En=1, Par_Typ=1 one cycle after rx_busy falls; cfg_pend=0.
- cfg_wr with prescale=12 -> cfg_rej pulses once, cfg_pend stays 0, Prescale stays 8.
- 5 rx_valid pulses carrying 0xA1..0xA5, rd_ready=0 (FIFO_DEPTH=4) -> fifo_count=4, ovf=1; then rd_ready=1 pops 0xA1..0xA4 in order, 0xA5 never appears; clr -> ovf=0.
- FIFO full with rx_valid and a pop in the same cycle (push 0xB0) -> fifo_count stays 4, ovf=0, 0xB0 read out last.
- 300 rx_stp_err pulses, one with rx_par_err in the same cycle -> err_cnt saturates at 255; clr together with one rx_par_err -> err_cnt=1.
